// File: rtl/pd_stream_sched.sv
// Round-robin scheduler sharing one serial pattern detector between two word requesters.
// Optional per-requester hit statistics are enabled with `define PD_STATS_EN.
module pd_stream_sched #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              pd_rst,
  output logic              stream_in,
  input  logic              pattern_found,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [CNT_W-1:0]  resp_hits,
  output logic [CNT_W-1:0]  match_cnt0,
  output logic [CNT_W-1:0]  match_cnt1
);
  localparam int KW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, RESP} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg;
  logic [KW-1:0]     bidx;
  logic [CNT_W-1:0]  hits;
  logic              id_q;
  logic              last_gnt;
  logic              gnt0, gnt1;
  logic              hit_inc;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_nx = state;
    case (state)
      IDLE: begin
        // last_gnt resets to 1 so requester 0 wins the first tie
        gnt0 = !rst && req0_valid && (!req1_valid || last_gnt);
        gnt1 = !rst && req1_valid && (!req0_valid || !last_gnt);
        if (gnt0 || gnt1) state_nx = SHIFT;
      end
      SHIFT:   if (bidx == KW'(DATA_W - 1)) state_nx = DRAIN;
      DRAIN:   state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Detector output at k=0 still reflects its reset; DRAIN picks up the final bit
  assign hit_inc = pattern_found &&
                   ((state == SHIFT && bidx != '0) || state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bidx     <= '0;
      hits     <= '0;
      id_q     <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nx;
      if (gnt0 || gnt1) begin
        shreg    <= gnt1 ? req1_data : req0_data;
        id_q     <= gnt1;
        last_gnt <= gnt1;
        hits     <= '0;
        bidx     <= '0;
      end else begin
        if (state == SHIFT) begin
          shreg <= shreg << 1;
          bidx  <= bidx + KW'(1);
        end
        if (hit_inc && hits != '1) hits <= hits + CNT_W'(1);
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign stream_in  = (state == SHIFT) && shreg[DATA_W-1];
  assign pd_rst     = rst || !(state == SHIFT || state == DRAIN);
  assign resp_valid = (state == RESP);
  assign resp_id    = id_q;
  assign resp_hits  = hits;

`ifdef PD_STATS_EN
  logic [CNT_W-1:0] cnt0, cnt1;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] sum_sat;

  assign sum     = {1'b0, (id_q ? cnt1 : cnt0)} + {1'b0, hits};
  assign sum_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (resp_valid && resp_ready) begin
      if (id_q) cnt1 <= sum_sat;
      else      cnt0 <= sum_sat;
    end
  end

  assign match_cnt0 = cnt0;
  assign match_cnt1 = cnt1;
`else
  assign match_cnt0 = '0;
  assign match_cnt1 = '0;
`endif
endmodule

// File: tb/tb_pd_stream_sched.sv
// Directed bench for pd_stream_sched with a registered overlapping 1101 detector model.
module tb_pd_stream_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       pd_rst, stream_in, pattern_found;
  logic       resp_valid, resp_ready = 1'b0, resp_id;
  logic [7:0] resp_hits, match_cnt0, match_cnt1;

  int n_chk  = 0;
  int n_fail = 0;

  pd_stream_sched #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pd_rst(pd_rst), .stream_in(stream_in), .pattern_found(pattern_found),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_hits(resp_hits), .match_cnt0(match_cnt0), .match_cnt1(match_cnt1)
  );

  always #5 clk = ~clk;

  // Detector: overlapping 1101, registered output, synchronous reset from pd_rst
  logic [2:0] hist;
  always_ff @(posedge clk) begin
    if (pd_rst) begin
      hist          <= '0;
      pattern_found <= 1'b0;
    end else begin
      hist          <= {hist[1:0], stream_in};
      pattern_found <= ({hist, stream_in} == 4'b1101);
    end
  end

  typedef struct {
    logic       r0v;
    logic [7:0] r0d;
    logic       r1v;
    logic [7:0] r1d;
    logic       eid;
    logic [7:0] ehits;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output int w);
    w = 0;
    while (!(req0_ready || req1_ready) && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    chk("grant_timeout", 32'(w < 20), 1);
  endtask

  task automatic do_frame(input vec_t v);
    logic [7:0] seq;
    logic       busy_bad;
    int         w;
    @(negedge clk);
    req0_valid = v.r0v; req0_data = v.r0d;
    req1_valid = v.r1v; req1_data = v.r1d;
    resp_ready = 1'b1;
    #1;
    wait_grant(w);
    if (w >= 20) return;
    chk("grant_id", {31'b0, req1_ready}, {31'b0, v.eid});
    chk("grant_excl", {31'b0, req0_ready & req1_ready}, 0);
    busy_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      seq[7-k] = stream_in;
      busy_bad |= req0_ready | req1_ready | pd_rst | resp_valid;
    end
    @(negedge clk); #1;
    busy_bad |= req0_ready | req1_ready | pd_rst | stream_in | resp_valid;
    chk("stream_bits", {24'b0, seq}, {24'b0, v.eid ? v.r1d : v.r0d});
    chk("busy_outputs", {31'b0, busy_bad}, 0);
    @(negedge clk); #1;
    chk("resp_valid", {31'b0, resp_valid}, 1);
    chk("resp_id", {31'b0, resp_id}, {31'b0, v.eid});
    chk("resp_hits", {24'b0, resp_hits}, {24'b0, v.ehits});
    chk("pd_rst_resp", {31'b0, pd_rst}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] exp_stat;
`ifdef PD_STATS_EN
    exp_stat = 8'd6;
`else
    exp_stat = 8'd0;
`endif
    vt[0] = '{1'b1, 8'hDA, 1'b0, 8'h00, 1'b0, 8'd2};
    vt[1] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'd0};
    vt[2] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'd0};
    vt[3] = '{1'b1, 8'h6D, 1'b1, 8'hDA, 1'b0, 8'd2};
    vt[4] = '{1'b1, 8'h6D, 1'b1, 8'hDA, 1'b1, 8'd2};
    vt[5] = '{1'b1, 8'h6D, 1'b1, 8'hDA, 1'b0, 8'd2};
    vt[6] = '{1'b1, 8'h6D, 1'b1, 8'hDA, 1'b1, 8'd2};

    // Reset state with both requesters asserting valid
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {30'b0, req0_ready, req1_ready}, 0);
    chk("rst_pd_rst", {31'b0, pd_rst}, 1);
    chk("rst_stream", {31'b0, stream_in}, 0);
    chk("rst_resp", {23'b0, resp_valid, resp_hits}, 0);
    chk("rst_cnts", {16'b0, match_cnt0, match_cnt1}, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_frame(vt[i]);

    // Response back-pressure: outputs stable, nothing granted, regrant right after handshake
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hDA; req1_valid = 1'b0; resp_ready = 1'b0;
    #1;
    wait_grant(w);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'hFF;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("hold_resp", {21'b0, resp_valid, resp_id, resp_hits, req0_ready, req1_ready},
          {21'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0});
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    chk("hold_hs_cycle", {30'b0, resp_valid, req1_ready}, 32'b10);
    @(negedge clk); #1;
    chk("regrant_next", {30'b0, req0_ready, req1_ready}, 32'b01);
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Reset at SHIFT k=3, then both valid: requester 0 must win again
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hDA;
    #1;
    wait_grant(w);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_pd_rst", {31'b0, pd_rst}, 1);
    chk("mid_rst_resp", {22'b0, resp_valid, stream_in, resp_hits}, 0);
    chk("mid_rst_cnts", {16'b0, match_cnt0, match_cnt1}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_idle", {30'b0, resp_valid, pd_rst}, 32'b01);
    do_frame(vt[3]);

    // Statistics over three 0xDA frames from requester 0
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) do_frame(vt[0]);
    @(negedge clk); #1;
    req0_valid = 1'b0;
    chk("stats_cnt0", {24'b0, match_cnt0}, {24'b0, exp_stat});
    chk("stats_cnt1", {24'b0, match_cnt1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pd_stream_sched.md
# pd_stream_sched

Scheduler that shares one serial pattern detector (the `PD_fsm` datapath: `clk`, `rst`, `stream_in`, `pattern_found`) between two word-wide requesters. The block accepts a `DATA_W`-bit word from a round-robin arbitrated requester and shifts it MSB-first into the detector, one bit per cycle. It counts the `pattern_found` pulses produced for that word and returns a tagged hit count through a valid/ready response port. The detector is held in reset between words, so every word is an independent frame.

## Interface
- `DATA_W`, 8: word width; number of serial bits per frame.
- `CNT_W`, 8: width of the hit count and the statistics counters.

Ports (all signals are in the `clk` domain):
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a word.
- `req0_data` in DATA_W: requester 0 word.
- `req0_ready` out 1: grant/accept pulse for requester 0.
- `req1_valid` in 1: requester 1 has a word.
- `req1_data` in DATA_W: requester 1 word.
- `req1_ready` out 1: grant/accept pulse for requester 1.
- `pd_rst` out 1: reset to the detector, active-high.
- `stream_in` out 1: serial bit to the detector.
- `pattern_found` in 1: registered (Moore) detector output; reflects bits up to the previous cycle.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts response.
- `resp_id` out 1: requester that owned the frame.
- `resp_hits` out CNT_W: `pattern_found` pulses counted for the frame.
- `match_cnt0` out CNT_W: cumulative hits for requester 0 (see Configuration).
- `match_cnt1` out CNT_W: cumulative hits for requester 1 (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE → SHIFT when a word is accepted.
  - SHIFT → DRAIN after DATA_W cycles.
  - DRAIN → RESP.
  - RESP → IDLE on `resp_valid & resp_ready`.
- Arbitration (IDLE only):
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester not granted last wins.
  - After reset, requester 0 has priority.
- In the grant cycle, `reqN_ready` is high combinationally for one cycle. The word is latched into the shift register, `resp_id` is set to N, and the hit counter is cleared.
- `reqN_ready` is never high outside IDLE. It is never high for both requesters at once, and never high without the matching `reqN_valid`.
- SHIFT:
  - A bit index counts k = 0..DATA_W-1.
  - `stream_in` = word[DATA_W-1-k].
  - The hit counter increments when `pattern_found`=1 and k≥1. At k=0 the detector output reflects reset.
- DRAIN:
  - `stream_in`=0.
  - The hit counter increments if `pattern_found`=1; this covers the final bit.
- `pd_rst`:
  - Low only in SHIFT and DRAIN.
  - High in IDLE and RESP, and while `rst` is high.
- RESP: `resp_valid`=1. `resp_id` and `resp_hits` are held stable until the handshake completes.
- Hit counter width is CNT_W. It saturates at 2^CNT_W-1 and never wraps.
- Requester valid/data changes while the block is busy are ignored. No new word is accepted until the block returns to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `pd_rst`=1.
  - `stream_in`=0.
  - `req0_ready`=`req1_ready`=0 (combinational, gated by `rst`).
  - `resp_valid`=0, `resp_id`=0, `resp_hits`=0.
  - `match_cnt0`=`match_cnt1`=0.
  - Round-robin pointer favours requester 0.
- Latency for a grant in cycle t:
  - SHIFT in t+1..t+DATA_W.
  - DRAIN in t+DATA_W+1.
  - `resp_valid` first high in t+DATA_W+2 (t+10 for DATA_W=8).
- Throughput: a new grant can occur no earlier than the cycle after the response handshake, so the minimum is DATA_W+3 cycles per word.
- `rst` asserted mid-frame: the frame is abandoned, no response is produced, and all outputs return to their reset values asynchronously.
- `resp_ready` may be held high continuously; RESP then lasts exactly one cycle.

## Configuration
- `PD_STATS_EN` defined:
  - On each response handshake, `resp_hits` is added to `match_cnt<resp_id>`.
  - The counters saturate at 2^CNT_W-1.
- `PD_STATS_EN` undefined: `match_cnt0` and `match_cnt1` are tied to 0 and no counter registers exist.

## Test plan
Scenarios use a bench model of the detector for pattern 1101 (overlapping, registered output, reset by `pd_rst`).
- Reset, then `req0` offers 0xDA with `resp_ready`=1 → `req0_ready` high at cycle t; `stream_in` sequence 1,1,0,1,1,0,1,0; `resp_valid` at t+10 with `resp_id`=0, `resp_hits`=2.
- `req1` offers 0x00, then 0xFF → `resp_hits`=0 for both; `pd_rst` high between frames.
- Both requesters valid continuously (0x6D on `req0`, 0xDA on `req1`) → grants alternate 0,1,0,1; each response has `resp_hits`=2.
- Hold `resp_ready`=0 for 5 cycles in RESP → `resp_valid`, `resp_id` and `resp_hits` are stable; no `reqN_ready` is asserted; the next grant comes one cycle after the handshake.
- Assert `rst` at SHIFT k=3 → `pd_rst`=1, `resp_valid`=0 and the counters are 0 immediately; the next word completes normally with correct hits.
- With `PD_STATS_EN`: three 0xDA frames from `req0` → `match_cnt0`=6, `match_cnt1`=0. Without the macro → both counters remain 0.
